// File: rtl/sprite_dma_pkg.sv
// rtl/sprite_dma_pkg.sv - shared config offsets, control/status bits and FSM states for sprite_dma
package sprite_dma_pkg;

  localparam logic [1:0] CFG_SRC_LO = 2'd0;
  localparam logic [1:0] CFG_SRC_HI = 2'd1;
  localparam logic [1:0] CFG_CTRL   = 2'd2;
  localparam logic [1:0] CFG_STATUS = 2'd3;

  localparam int CTRL_AUTO_BIT   = 0;
  localparam int CTRL_START_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WRITE,
    ST_DONE
  } dma_state_t;

endpackage

// File: rtl/sprite_dma_vsync_edge.sv
// rtl/sprite_dma_vsync_edge.sv - registers vsync and emits a one-cycle pulse on its rising edge
module sprite_dma_vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic rise
);

  logic vs_q;
  logic vs_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q    <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_q    <= vsync;
      vs_prev <= vs_q;
    end
  end

  assign rise = vs_q & ~vs_prev;

endmodule

// File: rtl/sprite_dma.sv
// rtl/sprite_dma.sv - copies NSPR*SPR_BYTES bytes from RAM into the sprite register files
module sprite_dma
  import sprite_dma_pkg::*;
#(
  parameter int NSPR      = 4,
  parameter int SPR_BYTES = 10,
  parameter int AW        = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_cs,
  input  logic            cfg_rw,
  input  logic [1:0]      cfg_addr,
  input  logic [7:0]      cfg_di,
  output logic [7:0]      cfg_dout,
  input  logic            vsync,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_di,
  output logic [NSPR-1:0] spr_sel,
  output logic            spr_rw,
  output logic [3:0]      spr_addr,
  output logic [7:0]      spr_do,
  output logic            busy
);

  localparam int SW = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(NSPR - 1);
  localparam logic [3:0]    B_LAST = 4'(SPR_BYTES - 1);

  dma_state_t    state, state_n;
  logic [15:0]   src_q;
  logic          auto_q;
  logic          done_q;
  logic [AW-1:0] ptr;
  logic [SW-1:0] s;
  logic [3:0]    b;
  logic [7:0]    data_q;
  logic          vsync_rise;
  logic          cfg_wr, cfg_rd, start_wr, trigger, last_byte;
  logic [7:0]    status;

  sprite_dma_vsync_edge u_vsync_edge (
    .clk   (clk),
    .reset (reset),
    .vsync (vsync),
    .rise  (vsync_rise)
  );

  assign cfg_wr    = cfg_cs & cfg_rw;
  assign cfg_rd    = cfg_cs & ~cfg_rw;
  assign start_wr  = cfg_wr && (cfg_addr == CFG_CTRL) && cfg_di[CTRL_START_BIT];
  assign trigger   = start_wr | (vsync_rise & auto_q);
  assign last_byte = (s == S_LAST) && (b == B_LAST);

  always_comb begin
    status = 8'h00;
    status[STATUS_BUSY_BIT] = busy;
    status[STATUS_DONE_BIT] = done_q;
  end

  // Config registers; start is never stored, so CTRL reads back only auto.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q    <= 16'h0000;
      auto_q   <= 1'b0;
      cfg_dout <= 8'h00;
    end else begin
      if (cfg_wr) begin
        case (cfg_addr)
          CFG_SRC_LO: src_q[7:0]  <= cfg_di;
          CFG_SRC_HI: src_q[15:8] <= cfg_di;
          CFG_CTRL:   auto_q      <= cfg_di[CTRL_AUTO_BIT];
          default:    ;
        endcase
      end
      if (cfg_rd) begin
        case (cfg_addr)
          CFG_SRC_LO: cfg_dout <= src_q[7:0];
          CFG_SRC_HI: cfg_dout <= src_q[15:8];
          CFG_CTRL:   cfg_dout <= {7'b0, auto_q};
          default:    cfg_dout <= status;
        endcase
      end
    end
  end

  // Completion wins over a CTRL write landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else if (state == ST_DONE) begin
      done_q <= 1'b1;
    end else if (cfg_wr && (cfg_addr == CFG_CTRL)) begin
      done_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
    end
  end

  // ptr is a working copy so SRC can be reprogrammed mid-transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      s      <= '0;
      b      <= 4'd0;
      data_q <= 8'h00;
    end else begin
      case (state)
        ST_LOAD: begin
          ptr <= AW'(src_q);
          s   <= '0;
          b   <= 4'd0;
        end
        ST_REQ: begin
          if (mem_ack) data_q <= mem_di;
        end
        ST_WRITE: begin
          ptr <= ptr + AW'(1);
          if (b == B_LAST) begin
            b <= 4'd0;
            s <= s + SW'(1);
          end else begin
            b <= b + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n  = state;
    mem_req  = 1'b0;
    mem_addr = '0;
    spr_sel  = '0;
    spr_rw   = 1'b0;
    spr_addr = 4'd0;
    spr_do   = 8'h00;
    case (state)
      ST_IDLE:  if (trigger) state_n = ST_LOAD;
      ST_LOAD:  state_n = ST_REQ;
      ST_REQ: begin
        mem_req  = 1'b1;
        mem_addr = ptr;
        if (mem_ack) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        spr_sel  = NSPR'(1) << s;
        spr_rw   = 1'b1;
        spr_addr = b;
        spr_do   = data_q;
        state_n  = last_byte ? ST_DONE : ST_REQ;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_dma.sv
// tb/tb_sprite_dma.sv - self-checking bench for sprite_dma
module tb_sprite_dma;
  import sprite_dma_pkg::*;

  localparam int NSPR = 4, SPR_BYTES = 10, AW = 16;
  localparam int NBYTES = NSPR * SPR_BYTES;
  localparam int LIMIT = 2000;

  logic clk = 1'b0, reset = 1'b0;
  logic cfg_cs = 1'b0, cfg_rw = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_di = 8'h00, cfg_dout;
  logic vsync = 1'b0;
  logic mem_req, mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_di = 8'h00;
  logic [NSPR-1:0] spr_sel;
  logic spr_rw, busy;
  logic [3:0] spr_addr;
  logic [7:0] spr_do;

  always #5 clk = ~clk;

  sprite_dma #(.NSPR(NSPR), .SPR_BYTES(SPR_BYTES), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cfg_cs(cfg_cs), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr),
    .cfg_di(cfg_di), .cfg_dout(cfg_dout), .vsync(vsync), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_di(mem_di), .spr_sel(spr_sel),
    .spr_rw(spr_rw), .spr_addr(spr_addr), .spr_do(spr_do), .busy(busy)
  );

  int n_total = 0, n_pass = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // RAM model and write monitor
  int ack_delay = 0, wait_cnt = 0;
  logic [7:0] salt = 8'h00;
  logic [15:0] held = 16'h0;
  logic prev_ack = 1'b0;
  int stab_err = 0, seq_err = 0, sel_err = 0;
  logic [15:0] wq[$];
  logic [15:0] aq[$];

  function automatic logic [7:0] ram_byte(logic [15:0] a);
    return a[7:0] ^ salt;
  endfunction

  function automatic logic [15:0] exp_entry(logic [15:0] base, int i);
    logic [15:0] a = base + 16'(i);
    logic [3:0] sel = 4'(1 << (i / SPR_BYTES));
    return {sel, 4'(i % SPR_BYTES), ram_byte(a)};
  endfunction

  always @(negedge clk) begin
    if (spr_rw) begin
      wq.push_back({spr_sel, spr_addr, spr_do});
      if (!prev_ack) seq_err++;
    end else if (spr_sel != '0) begin
      sel_err++;
    end
    if (mem_req) begin
      if (wait_cnt == 0) begin
        aq.push_back(mem_addr);
        held = mem_addr;
      end else if (mem_addr != held) begin
        stab_err++;
      end
      mem_ack = (wait_cnt == ack_delay);
      mem_di = mem_ack ? ram_byte(mem_addr) : 8'($urandom);
      wait_cnt++;
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
    prev_ack = mem_ack;
  end

  task automatic cfg_write(logic [1:0] a, logic [7:0] d);
    @(negedge clk);
    cfg_cs = 1'b1; cfg_rw = 1'b1; cfg_addr = a; cfg_di = d;
    @(negedge clk);
    cfg_cs = 1'b0; cfg_rw = 1'b0;
  endtask

  task automatic cfg_read(logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cfg_cs = 1'b1; cfg_rw = 1'b0; cfg_addr = a;
    @(negedge clk);
    d = cfg_dout;
    cfg_cs = 1'b0;
  endtask

  task automatic start_xfer(logic [15:0] base);
    wq.delete(); aq.delete();
    cfg_write(CFG_SRC_LO, base[7:0]);
    cfg_write(CFG_SRC_HI, base[15:8]);
    cfg_write(CFG_CTRL, 8'h02);
  endtask

  task automatic wait_idle(string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < LIMIT);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic check_writes(string name, logic [15:0] base);
    int bad = 0;
    check({name, "_count"}, wq.size(), NBYTES);
    for (int i = 0; i < wq.size() && i < NBYTES; i++)
      if (wq[i] !== exp_entry(base, i)) bad++;
    check({name, "_data_errs"}, bad, 0);
  endtask

  typedef struct {
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic [1:0] raddr;
    logic [7:0] exp;
  } cfg_vec_t;
  cfg_vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int n;

    vecs[0] = '{CFG_SRC_LO, 8'h12, CFG_SRC_LO, 8'h12};
    vecs[1] = '{CFG_SRC_HI, 8'hAB, CFG_SRC_HI, 8'hAB};
    vecs[2] = '{CFG_CTRL,   8'h01, CFG_CTRL,   8'h01};
    vecs[3] = '{CFG_CTRL,   8'hFC, CFG_CTRL,   8'h00};
    vecs[4] = '{CFG_STATUS, 8'h55, CFG_STATUS, 8'h00};
    vecs[5] = '{CFG_SRC_LO, 8'h34, CFG_SRC_HI, 8'hAB};

    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, mem_req, mem_addr, spr_sel, spr_rw, spr_addr, spr_do, cfg_dout}, 0);
    reset = 1'b1;
    cfg_read(CFG_STATUS, d);
    check("rst_status", d, 8'h00);
    cfg_read(CFG_SRC_HI, d);
    check("rst_src_hi", d, 8'h00);

    foreach (vecs[i]) begin
      cfg_write(vecs[i].waddr, vecs[i].wdata);
      cfg_read(vecs[i].raddr, d);
      check($sformatf("cfg_vec%0d", i), d, vecs[i].exp);
    end

    // basic transfer, zero-wait RAM
    start_xfer(16'h1234);
    wait_idle("t2", n);
    check("t2_cycles", n, 82);
    check_writes("t2", 16'h1234);
    if (wq.size() >= NBYTES) begin
      check("t2_first", wq[0], 16'h1034);
      check("t2_last", wq[NBYTES-1], 16'h895B);
    end
    cfg_read(CFG_STATUS, d);
    check("t2_status", d, 8'h02);

    // address wrap
    start_xfer(16'hFFFE);
    wait_idle("t3", n);
    check_writes("t3", 16'hFFFE);
    if (aq.size() >= 4) check("t3_addr_wrap", {aq[0], aq[1], aq[2], aq[3]}, 64'hFFFE_FFFF_0000_0001);
    else check("t3_addr_count", aq.size(), 4);

    // slow RAM
    ack_delay = 3;
    start_xfer(16'h2040);
    wait_idle("t4", n);
    check("t4_cycles", n, 202);
    check_writes("t4", 16'h2040);
    ack_delay = 0;

    // vsync auto trigger, retriggers while busy ignored
    cfg_write(CFG_SRC_LO, 8'h00);
    cfg_write(CFG_SRC_HI, 8'h30);
    wq.delete();
    cfg_write(CFG_CTRL, 8'h01);
    vsync = 1'b1;
    @(negedge clk);
    check("t5_busy_lag", busy, 0);
    @(negedge clk);
    check("t5_busy_start", busy, 1);
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    cfg_write(CFG_CTRL, 8'h03);
    vsync = 1'b0;
    wait_idle("t5", n);
    repeat (5) @(negedge clk);
    check("t5_no_requeue", busy, 0);
    check_writes("t5", 16'h3000);
    cfg_write(CFG_CTRL, 8'h00);

    // SRC rewritten mid-transfer
    start_xfer(16'h1234);
    repeat (10) @(negedge clk);
    cfg_write(CFG_SRC_LO, 8'h00);
    wait_idle("t6a", n);
    check_writes("t6_old", 16'h1234);
    wq.delete();
    cfg_write(CFG_CTRL, 8'h02);
    wait_idle("t6b", n);
    check_writes("t6_new", 16'h1200);

    // CTRL write on the same edge that sets done
    start_xfer(16'h1234);
    repeat (80) @(negedge clk);
    cfg_write(CFG_CTRL, 8'h00);
    check("dp_busy", busy, 0);
    cfg_read(CFG_STATUS, d);
    check("dp_done_kept", d, 8'h02);
    cfg_write(CFG_CTRL, 8'h00);
    cfg_read(CFG_STATUS, d);
    check("dp_done_cleared", d, 8'h00);

    // reset mid-REQ
    ack_delay = 20;
    cfg_write(CFG_SRC_LO, 8'h55);
    cfg_write(CFG_SRC_HI, 8'h40);
    cfg_read(CFG_SRC_LO, d);
    check("t1_pre_dout", d, 8'h55);
    cfg_write(CFG_CTRL, 8'h02);
    repeat (3) @(negedge clk);
    check("t1_in_req", mem_req, 1);
    reset = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_mem_req", mem_req, 0);
    check("t1_spr_sel", spr_sel, 0);
    check("t1_cfg_dout", cfg_dout, 0);
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    cfg_read(CFG_STATUS, d);
    check("t1_status", d, 8'h00);
    cfg_read(CFG_SRC_LO, d);
    check("t1_src_lo", d, 8'h00);

    // randomized transfers against the model
    for (int r = 0; r < 4; r++) begin
      logic [15:0] base = 16'($urandom);
      ack_delay = $urandom_range(0, 3);
      salt = 8'($urandom);
      start_xfer(base);
      wait_idle($sformatf("rnd%0d", r), n);
      check($sformatf("rnd%0d_cycles", r), n, 2 + NBYTES * (ack_delay + 2));
      check_writes($sformatf("rnd%0d", r), base);
    end

    check("mon_addr_stable", stab_err, 0);
    check("mon_write_after_ack", seq_err, 0);
    check("mon_sel_outside_write", sel_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
